seg_scan_ctrl: RTL and testbench

- Scan controller for the 4-digit seven-segment display; replaces the derived-clock approach with an internal programmable prescaler that emits single-cycle enables in the clk_in domain.
- Sequences digit anodes round-robin, inserts a blanking gap at each switch to suppress ghosting, and decodes hex nibbles to segments.
- Runtime-reconfigurable scan period through a load/ack handshake; sits between the top-level data registers and the board display pins.

---
 rtl/seg_scan_ctrl.sv | 112 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: prescaled round-robin scan of a 4-digit seven-segment display with anti-ghost blanking
module seg_scan_ctrl #(
   parameter int DIV_W     = 20,
   parameter int DEF_DIV   = 100000,
   parameter int BLANK_CYC = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_value,
   output logic             div_ack,
   input  logic [15:0]      digits,
   input  logic [3:0]       dp,
   input  logic             blank_en,
   output logic [3:0]       an,
   output logic [6:0]       seg,
   output logic             dp_out,
   output logic             scan_tick
);

   localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(BLANK_CYC + 2);
   localparam logic [DIV_W-1:0] RST_DIV = (DEF_DIV > BLANK_CYC + 2) ? DIV_W'(DEF_DIV) : MIN_DIV;
   localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t           state;
   logic [DIV_W-1:0] count;
   logic [DIV_W-1:0] period;
   logic [BW-1:0]    bcnt;
   logic [1:0]       idx;
   logic             terminal;
   logic             tick_now;
   logic [3:0]       nib;
   logic             supp;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'b1000000;
         4'h1: decode = 7'b1111001;
         4'h2: decode = 7'b0100100;
         4'h3: decode = 7'b0110000;
         4'h4: decode = 7'b0011001;
         4'h5: decode = 7'b0010010;
         4'h6: decode = 7'b0000010;
         4'h7: decode = 7'b1111000;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0010000;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b0000011;
         4'hC: decode = 7'b1000110;
         4'hD: decode = 7'b0100001;
         4'hE: decode = 7'b0000110;
         default: decode = 7'b0001110;
      endcase
   endfunction

   // a load in the same cycle as terminal count restarts the period and swallows the tick
   assign terminal = count == period - DIV_W'(1);
   assign tick_now = terminal && !div_load;
   assign nib      = digits[{idx, 2'b00} +: 4];
   assign supp     = blank_en && idx != 2'd0 && (digits >> {idx, 2'b00}) == 16'h0;

   // prescaler with runtime-loadable, clamped period and load acknowledge
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         count     <= '0;
         period    <= RST_DIV;
         scan_tick <= 1'b0;
         div_ack   <= 1'b0;
      end else begin
         div_ack   <= div_load;
         scan_tick <= tick_now;
         if (div_load) begin
            period <= (div_value < MIN_DIV) ? MIN_DIV : div_value;
            count  <= '0;
         end else begin
            count <= terminal ? '0 : count + DIV_W'(1);
         end
      end
   end

   // blank/show sequencer; digit outputs are snapshotted on show entry so they never change mid-digit
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state  <= BLANK;
         bcnt   <= '0;
         idx    <= 2'd0;
         an     <= 4'hF;
         seg    <= 7'h7F;
         dp_out <= 1'b1;
      end else if (state == BLANK) begin
         if (bcnt == BLANK_LAST) begin
            state  <= SHOW;
            bcnt   <= '0;
            an     <= ~(4'b0001 << idx);
            seg    <= supp ? 7'h7F : decode(nib);
            dp_out <= ~dp[idx];
         end else begin
            bcnt <= bcnt + BW'(1);
         end
      end else if (tick_now) begin
         state  <= BLANK;
         idx    <= idx + 2'd1;
         an     <= 4'hF;
         seg    <= 7'h7F;
         dp_out <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl against a timestamp-based reference model
module tb_seg_scan_ctrl;

   localparam int DIV_W     = 20;
   localparam int DEF_DIV   = 10;
   localparam int BLANK_CYC = 4;

   localparam logic [11:0] BLANK_V = {4'hF, 7'h7F, 1'b1};
   localparam logic [13:0] RST_OUT = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
   localparam logic [6:0] LUT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic             clk_in = 1'b0;
   logic             reset = 1'b1;
   logic             div_load = 1'b0;
   logic [DIV_W-1:0] div_value = '0;
   logic [15:0]      digits = 16'h0;
   logic [3:0]       dp = 4'h0;
   logic             blank_en = 1'b0;
   logic             div_ack;
   logic [3:0]       an;
   logic [6:0]       seg;
   logic             dp_out;
   logic             scan_tick;

   seg_scan_ctrl #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk_in(clk_in), .reset(reset), .div_load(div_load), .div_value(div_value),
      .div_ack(div_ack), .digits(digits), .dp(dp), .blank_en(blank_en),
      .an(an), .seg(seg), .dp_out(dp_out), .scan_tick(scan_tick));

   always #5 clk_in = ~clk_in;

   typedef struct {int e; logic [11:0] v;} show_t;

   int          vectors = 0;
   int          errors = 0;
   int          k = 0;
   int          restart = 0;
   int          period = DEF_DIV;
   int          bstart = 0;
   int          idx = 0;
   int          last_edge = -1;
   bit          in_show = 0;
   bit          term;
   bit          tick;
   int          tick_q[$];
   int          ack_q[$];
   show_t       show_q[$];
   show_t       s;
   logic [11:0] cur = BLANK_V;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, last_edge);
      end
   endfunction

   function automatic int clamp(input int v);
      return (v < BLANK_CYC + 2) ? BLANK_CYC + 2 : v;
   endfunction

   function automatic logic [11:0] display(input int i, input logic [15:0] d, input logic [3:0] p, input logic be);
      logic [3:0] a;
      logic [3:0] n;
      bit         sup;
      a = 4'hF;
      a[i] = 1'b0;
      n = d[4*i +: 4];
      sup = be && i > 0;
      for (int j = i; j < 4; j++) if (d[4*j +: 4] != 4'h0) sup = 0;
      return {a, sup ? 7'h7F : LUT[n], ~p[i]};
   endfunction

   // reference model: edge k is terminal when k-restart == period-1; show starts BLANK_CYC edges after blanking starts
   always @(posedge clk_in) begin
      if (!reset) begin
         k = 0; restart = 0; period = clamp(DEF_DIV); bstart = 0; idx = 0;
         in_show = 0; last_edge = -1; cur = BLANK_V;
         tick_q.delete(); ack_q.delete(); show_q.delete();
      end else begin
         term = (k - restart == period - 1);
         tick = term && !div_load;
         if (div_load) begin
            ack_q.push_back(k);
            restart = k + 1;
            period = clamp(int'(div_value));
         end else if (term) begin
            restart = k + 1;
         end
         if (tick) tick_q.push_back(k);
         if (!in_show && k == bstart + BLANK_CYC - 1) begin
            in_show = 1;
            show_q.push_back('{k, display(idx, digits, dp, blank_en)});
         end else if (in_show && tick) begin
            in_show = 0;
            idx = (idx + 1) % 4;
            bstart = k + 1;
         end
         last_edge = k;
         k++;
      end
   end

   // monitor: pops expectations as the DUT presents pulses and digits
   always @(negedge clk_in) begin
      if (reset && last_edge >= 0) begin
         if (scan_tick || (tick_q.size() > 0 && tick_q[0] <= last_edge))
            chk("scan_tick_edge", scan_tick ? last_edge : -1, tick_q.size() > 0 ? tick_q.pop_front() : -1);
         if (div_ack || (ack_q.size() > 0 && ack_q[0] <= last_edge))
            chk("div_ack_edge", div_ack ? last_edge : -1, ack_q.size() > 0 ? ack_q.pop_front() : -1);
         if (show_q.size() > 0 && show_q[0].e <= last_edge) begin
            s = show_q.pop_front();
            cur = s.v;
         end
         chk("display", {20'h0, an, seg, dp_out}, {20'h0, in_show ? cur : BLANK_V});
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic load(input int v);
      div_value = DIV_W'(v);
      div_load = 1'b1;
      step(1);
      div_load = 1'b0;
   endtask

   task automatic wait_show();
      int g = 0;
      while (!in_show && g < 200) begin
         step(1);
         g++;
      end
      if (g >= 200) chk("wait_show_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(posedge clk_in);
      #2 reset = 1'b0;
      #1 chk("reset_outputs", {18'h0, an, seg, dp_out, scan_tick, div_ack}, {18'h0, RST_OUT});
      repeat (2) @(posedge clk_in);
      #2 reset = 1'b1;
   endtask

   initial begin
      int g;
      logic [15:0] d;
      digits = 16'hF1A0;
      dp = 4'b0100;
      blank_en = 1'b0;
      #2 reset = 1'b0;
      #1 chk("reset_state", {18'h0, an, seg, dp_out, scan_tick, div_ack}, {18'h0, RST_OUT});
      repeat (2) @(posedge clk_in);
      #2 reset = 1'b1;
      step(50);
      digits = 16'h0050; dp = 4'h0; blank_en = 1'b1;
      step(45);
      digits = 16'h0000;
      step(45);
      load(20);
      step(70);
      load(3);
      step(40);
      g = 0;
      while (!(k - restart == period - 1) && g < 100) begin
         step(1);
         g++;
      end
      if (g >= 100) chk("terminal_wait_timeout", 0, 1);
      load(7);
      step(30);
      div_value = DIV_W'(8);
      div_load = 1'b1;
      step(3);
      div_load = 1'b0;
      step(40);
      digits = 16'h3C07; dp = 4'b1010; blank_en = 1'b0;
      wait_show();
      step(1);
      digits = 16'h8888; dp = 4'h0;
      step(40);
      repeat (600) begin
         if ($urandom_range(0, 19) == 0) begin
            for (int j = 0; j < 4; j++) d[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            digits = d;
            dp = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 29) == 0) blank_en = ~blank_en;
         div_load = ($urandom_range(0, 39) == 0);
         div_value = DIV_W'($urandom_range(0, 25));
         step(1);
      end
      div_load = 1'b0;
      load(15);
      step(20);
      wait_show();
      step(2);
      do_reset();
      step(40);
      @(negedge clk_in);
      #1;
      chk("tick_q_left", tick_q.size(), 0);
      chk("ack_q_left", ack_q.size(), 0);
      chk("show_q_left", show_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
